// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch buffer
//   fetch_entry_t : {pc, instr} pair buffered for decode
//   fetch_state_e : RUN (issuing requests) / DRAIN (discarding stale responses)
//   cnt_width()   : occupancy counter width for a given depth (holds 0..depth)
package fetch_pkg;

   localparam int FETCH_PC_W    = 32;
   localparam int FETCH_INSTR_W = 32;
   localparam int FETCH_DEPTH   = 4;
   localparam int CNT_W         = $clog2(FETCH_DEPTH) + 1;

   typedef struct packed {
      logic [FETCH_PC_W-1:0]    pc;
      logic [FETCH_INSTR_W-1:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fetch_state_e;

   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with clear, used for pending PCs and fetched entries
//   clk, rstn      : clock, synchronous active-low reset
//   clear_i        : empty the FIFO next edge (wins over push/pop)
//   push_i/_data_i : write; accepted when not full, or when full and popping the same cycle
//   pop_i          : read; pop_data_o shows the head entry combinationally
//   full_o/empty_o/count_o : occupancy status
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   clear_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       push_data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       pop_data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o     = (count_q == (AW+1)'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign pop_data_o = mem_q[rd_ptr_q];

   assign do_pop  = pop_i & ~empty_o;
   // A push into a full FIFO is fine when the head leaves in the same cycle.
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk) begin
      if (!rstn || clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/instr_fetch_buffer.sv
// rtl/instr_fetch_buffer.sv - in-order instruction fetch with PC pairing, credit flow control and redirect flush
//   pc_in/pc_in_valid/pc_ready        : fetch address from the PC register; pc_ready = request accepted
//   flush                             : redirect, drop everything buffered and in flight
//   imem_req_valid/_ready/_addr       : instruction-memory read request (address = pc_in, same cycle)
//   imem_rsp_valid/_data              : in-order read response, no backpressure
//   instr_valid/_ready/instr_pc/_data : {pc, instr} stream to decode
//   err_unexp_rsp                     : sticky, response arrived with nothing outstanding
module instr_fetch_buffer
   import fetch_pkg::*;
#(
   parameter int PC_WIDTH    = FETCH_PC_W,
   parameter int INSTR_WIDTH = FETCH_INSTR_W,
   parameter int DEPTH       = FETCH_DEPTH
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [PC_WIDTH-1:0]    pc_in,
   input  logic                   pc_in_valid,
   output logic                   pc_ready,
   input  logic                   flush,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [PC_WIDTH-1:0]    imem_req_addr,
   input  logic                   imem_rsp_valid,
   input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [PC_WIDTH-1:0]    instr_pc,
   output logic [INSTR_WIDTH-1:0] instr_data,
   output logic                   err_unexp_rsp
);

   localparam int CW = cnt_width(DEPTH);

   fetch_state_e  state_q, state_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic          err_q, err_d;

   logic          credit;
   logic          fire;
   logic          rsp_ok;
   logic          rsp_unexp;
   logic          pend_pop;
   logic          instr_push;
   logic          instr_pop;
   logic [CW:0]   in_use;
   logic [CW-1:0] left_in_flight;

   logic [PC_WIDTH-1:0] pend_pc;
   logic                pend_full, pend_empty;
   logic [CW-1:0]       pend_count;
   logic                instr_full, instr_empty;
   logic [CW-1:0]       instr_count;
   fetch_entry_t        instr_in, instr_out;
   logic                unused_fifo_status;

   // Every request in flight owns a future slot in the instr FIFO, so limiting
   // (in flight + buffered) to DEPTH means a response always has somewhere to go.
   assign in_use = {1'b0, outstanding_q} + {1'b0, instr_count};
   assign credit = (in_use < (CW+1)'(DEPTH));

   assign imem_req_valid = pc_in_valid & credit & ~flush & (state_q == RUN);
   assign imem_req_addr  = pc_in;
   assign fire           = imem_req_valid & imem_req_ready;
   assign pc_ready       = fire;

   assign rsp_unexp      = imem_rsp_valid & (outstanding_q == '0);
   assign rsp_ok         = imem_rsp_valid & ~rsp_unexp;
   assign left_in_flight = outstanding_q - CW'(rsp_ok);

   always_comb begin
      state_d       = state_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      err_d         = err_q | rsp_unexp;
      pend_pop      = 1'b0;
      instr_push    = 1'b0;
      if (flush) begin
         // This cycle's response is dropped; whatever is still in flight
         // must come back and be discarded before new requests go out.
         outstanding_d = left_in_flight;
         drop_cnt_d    = left_in_flight;
         state_d       = (left_in_flight != '0) ? DRAIN : RUN;
      end else begin
         unique case (state_q)
            RUN: begin
               pend_pop      = rsp_ok;
               instr_push    = rsp_ok;
               outstanding_d = outstanding_q + CW'(fire) - CW'(rsp_ok);
            end
            DRAIN: begin
               if (rsp_ok) begin
                  outstanding_d = outstanding_q - 1'b1;
                  drop_cnt_d    = drop_cnt_q - 1'b1;
                  if (drop_cnt_q == CW'(1)) state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q       <= RUN;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         err_q         <= err_d;
      end
   end

   fetch_fifo #(
      .WIDTH (PC_WIDTH),
      .DEPTH (DEPTH)
   ) u_pend_fifo (
      .clk         (clk),
      .rstn        (rstn),
      .clear_i     (flush),
      .push_i      (fire),
      .push_data_i (pc_in),
      .pop_i       (pend_pop),
      .pop_data_o  (pend_pc),
      .full_o      (pend_full),
      .empty_o     (pend_empty),
      .count_o     (pend_count)
   );

   assign instr_in = '{pc: pend_pc, instr: imem_rsp_data};

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_instr_fifo (
      .clk         (clk),
      .rstn        (rstn),
      .clear_i     (flush),
      .push_i      (instr_push),
      .push_data_i (instr_in),
      .pop_i       (instr_pop),
      .pop_data_o  (instr_out),
      .full_o      (instr_full),
      .empty_o     (instr_empty),
      .count_o     (instr_count)
   );

   assign unused_fifo_status = ^{pend_full, pend_empty, pend_count, instr_full};

   assign instr_valid   = ~instr_empty;
   assign instr_pop     = instr_valid & instr_ready;
   assign instr_pc      = instr_out.pc;
   assign instr_data    = instr_out.instr;
   assign err_unexp_rsp = err_q;

endmodule
